// File: rtl/ibex_rf_wport_arbiter.sv
// Arbitrates the single register-file write port between ID/EX results and LSU load data.
// Tracks in-flight load destinations in order and holds one displaced ID/EX result.
module ibex_rf_wport_arbiter #(
    parameter int unsigned MaxLoads = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        id_we_i,
    input  logic [4:0]  id_waddr_i,
    input  logic [31:0] id_wdata_i,
    output logic        id_ready_o,
    input  logic        load_issue_i,
    input  logic [4:0]  load_waddr_i,
    output logic        load_ready_o,
    input  logic        lsu_rvalid_i,
    input  logic        lsu_err_i,
    input  logic [31:0] lsu_rdata_i,
    input  logic [4:0]  rs1_addr_i,
    input  logic [4:0]  rs2_addr_i,
    output logic        rs1_hazard_o,
    output logic        rs2_hazard_o,
    output logic [2:0]  loads_pending_o,
    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o
);

    // Storage is sized for the largest legal depth; pointers wrap at MaxLoads.
    localparam int unsigned Depth = 4;

    logic [4:0]       fifo_waddr [Depth];
    logic [Depth-1:0] fifo_valid_reg, fifo_valid_next;
    logic [1:0]       rd_ptr_reg, rd_ptr_next;
    logic [1:0]       wr_ptr_reg, wr_ptr_next;
    logic [2:0]       count_reg, count_next;
    logic             buf_valid_reg, buf_valid_next;
    logic [4:0]       buf_waddr_reg, buf_waddr_next;
    logic [31:0]      buf_wdata_reg, buf_wdata_next;

    logic             lsu_pop, lsu_write, load_push, id_accept;
    logic             sel_valid;
    logic [4:0]       sel_waddr;
    logic [31:0]      sel_wdata;
    logic [Depth-1:0] rs1_match, rs2_match;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (32'(p) == MaxLoads - 1) ? 2'd0 : p + 2'd1;
    endfunction

    // A response arriving with nothing outstanding is ignored entirely.
    assign lsu_pop   = lsu_rvalid_i & (count_reg != 3'd0);
    assign lsu_write = lsu_pop & ~lsu_err_i;

    assign load_ready_o    = (32'(count_reg) < MaxLoads) & ~buf_valid_reg;
    assign id_ready_o      = ~buf_valid_reg;
    assign load_push       = load_issue_i & load_ready_o;
    assign id_accept       = id_we_i & id_ready_o;
    assign loads_pending_o = count_reg;

    always_comb begin
        sel_valid = 1'b0;
        sel_waddr = 5'd0;
        sel_wdata = 32'd0;
        if (lsu_write) begin
            sel_valid = 1'b1;
            sel_waddr = fifo_waddr[rd_ptr_reg];
            sel_wdata = lsu_rdata_i;
        end else if (buf_valid_reg) begin
            sel_valid = 1'b1;
            sel_waddr = buf_waddr_reg;
            sel_wdata = buf_wdata_reg;
        end else if (id_accept) begin
            sel_valid = 1'b1;
            sel_waddr = id_waddr_i;
            sel_wdata = id_wdata_i;
        end
    end

    // x0 writes are consumed but never reach the register file.
    assign rf_we_o    = rst_ni & sel_valid & (sel_waddr != 5'd0);
    assign rf_waddr_o = rf_we_o ? sel_waddr : 5'd0;
    assign rf_wdata_o = rf_we_o ? sel_wdata : 32'd0;

    always_comb begin
        fifo_valid_next = fifo_valid_reg;
        rd_ptr_next     = rd_ptr_reg;
        wr_ptr_next     = wr_ptr_reg;
        count_next      = count_reg;
        if (lsu_pop) begin
            fifo_valid_next[rd_ptr_reg] = 1'b0;
            rd_ptr_next                 = ptr_inc(rd_ptr_reg);
        end
        if (load_push) begin
            fifo_valid_next[wr_ptr_reg] = 1'b1;
            wr_ptr_next                 = ptr_inc(wr_ptr_reg);
        end
        if (load_push && !lsu_pop) begin
            count_next = count_reg + 3'd1;
        end else if (!load_push && lsu_pop) begin
            count_next = count_reg - 3'd1;
        end
    end

    // A valid buffer stays only while the LSU keeps the port; otherwise capture on collision.
    always_comb begin
        buf_valid_next = buf_valid_reg ? lsu_write : (id_accept & lsu_write);
        buf_waddr_next = buf_waddr_reg;
        buf_wdata_next = buf_wdata_reg;
        if (id_accept && lsu_write) begin
            buf_waddr_next = id_waddr_i;
            buf_wdata_next = id_wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fifo_valid_reg <= '0;
            rd_ptr_reg     <= 2'd0;
            wr_ptr_reg     <= 2'd0;
            count_reg      <= 3'd0;
            buf_valid_reg  <= 1'b0;
            buf_waddr_reg  <= 5'd0;
            buf_wdata_reg  <= 32'd0;
        end else begin
            fifo_valid_reg <= fifo_valid_next;
            rd_ptr_reg     <= rd_ptr_next;
            wr_ptr_reg     <= wr_ptr_next;
            count_reg      <= count_next;
            buf_valid_reg  <= buf_valid_next;
            buf_waddr_reg  <= buf_waddr_next;
            buf_wdata_reg  <= buf_wdata_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (load_push) begin
            fifo_waddr[wr_ptr_reg] <= load_waddr_i;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < Depth; gi++) begin : g_match
            assign rs1_match[gi] = fifo_valid_reg[gi] & (fifo_waddr[gi] == rs1_addr_i);
            assign rs2_match[gi] = fifo_valid_reg[gi] & (fifo_waddr[gi] == rs2_addr_i);
        end
    endgenerate

    assign rs1_hazard_o = (rs1_addr_i != 5'd0) &
                          ((|rs1_match) | (buf_valid_reg & (buf_waddr_reg == rs1_addr_i)));
    assign rs2_hazard_o = (rs2_addr_i != 5'd0) &
                          ((|rs2_match) | (buf_valid_reg & (buf_waddr_reg == rs2_addr_i)));

endmodule

// File: tb/tb_ibex_rf_wport_arbiter.sv
// Directed scenarios plus randomized traffic checked against a queue-based model of the write port.
module tb_ibex_rf_wport_arbiter;

    localparam int MAX_LOADS = 2;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        id_we = 1'b0;
    logic [4:0]  id_waddr = '0;
    logic [31:0] id_wdata = '0;
    logic        id_ready;
    logic        load_issue = 1'b0;
    logic [4:0]  load_waddr = '0;
    logic        load_ready;
    logic        lsu_rvalid = 1'b0;
    logic        lsu_err = 1'b0;
    logic [31:0] lsu_rdata = '0;
    logic [4:0]  rs1_addr = '0;
    logic [4:0]  rs2_addr = '0;
    logic        rs1_hazard, rs2_hazard;
    logic [2:0]  loads_pending;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ibex_rf_wport_arbiter #(.MaxLoads(MAX_LOADS)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .id_we_i(id_we), .id_waddr_i(id_waddr), .id_wdata_i(id_wdata), .id_ready_o(id_ready),
        .load_issue_i(load_issue), .load_waddr_i(load_waddr), .load_ready_o(load_ready),
        .lsu_rvalid_i(lsu_rvalid), .lsu_err_i(lsu_err), .lsu_rdata_i(lsu_rdata),
        .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr),
        .rs1_hazard_o(rs1_hazard), .rs2_hazard_o(rs2_hazard),
        .loads_pending_o(loads_pending),
        .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata)
    );

    task automatic idle();
        id_we = 0; id_waddr = 0; id_wdata = 0;
        load_issue = 0; load_waddr = 0;
        lsu_rvalid = 0; lsu_err = 0; lsu_rdata = 0;
        rs1_addr = 0; rs2_addr = 0;
    endtask

    task automatic next();
        @(negedge clk);
        idle();
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst_ni = 0;
        @(negedge clk);
        rst_ni = 1;
    endtask

    task automatic test_reset();
        idle();
        rst_ni = 0;
        #1;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata, id_ready, load_ready, rs1_hazard, rs2_hazard, loads_pending}
            !== {1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0}) begin
            failures++;
            $display("FAIL reset we=%b wa=%0d wd=%h idr=%b ldr=%b hz=%b%b pend=%0d required 0/0/0/1/1/00/0",
                     rf_we, rf_waddr, rf_wdata, id_ready, load_ready, rs1_hazard, rs2_hazard, loads_pending);
        end
        @(negedge clk);
        rst_ni = 1;
        $display("reset: done");
    endtask

    task automatic test_direct_write();
        next();
        id_we = 1; id_waddr = 5; id_wdata = 32'hDEADBEEF;
        #1;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata, id_ready} !== {1'b1, 5'd5, 32'hDEADBEEF, 1'b1}) begin
            failures++;
            $display("FAIL direct_write we=%b wa=%0d wd=%h idr=%b required 1/5/deadbeef/1",
                     rf_we, rf_waddr, rf_wdata, id_ready);
        end
        $display("direct_write: x5 <= deadbeef");
    endtask

    task automatic test_load_order();
        next(); load_issue = 1; load_waddr = 3;
        next(); load_issue = 1; load_waddr = 7;
        next(); rs1_addr = 7;
        #1;
        checks++;
        if ({loads_pending, load_ready, rs1_hazard} !== {3'd2, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL load_full pend=%0d ldr=%b hz1=%b required 2/0/1", loads_pending, load_ready, rs1_hazard);
        end
        lsu_rvalid = 1; lsu_rdata = 32'h11;
        #1;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd3, 32'h11}) begin
            failures++;
            $display("FAIL load_resp1 we=%b wa=%0d wd=%h required 1/3/11", rf_we, rf_waddr, rf_wdata);
        end
        next(); lsu_rvalid = 1; lsu_rdata = 32'h22;
        #1;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd7, 32'h22}) begin
            failures++;
            $display("FAIL load_resp2 we=%b wa=%0d wd=%h required 1/7/22", rf_we, rf_waddr, rf_wdata);
        end
        next();
        #1;
        checks++;
        if (loads_pending !== 3'd0 || load_ready !== 1'b1) begin
            failures++;
            $display("FAIL load_drain pend=%0d ldr=%b required 0/1", loads_pending, load_ready);
        end
        $display("load_order: x3 then x7 written in order");
    endtask

    task automatic test_collision();
        next(); load_issue = 1; load_waddr = 4;
        next(); lsu_rvalid = 1; lsu_rdata = 32'hAA; id_we = 1; id_waddr = 9; id_wdata = 32'h55;
        #1;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata, id_ready} !== {1'b1, 5'd4, 32'hAA, 1'b1}) begin
            failures++;
            $display("FAIL collide_lsu we=%b wa=%0d wd=%h idr=%b required 1/4/aa/1", rf_we, rf_waddr, rf_wdata, id_ready);
        end
        next(); rs2_addr = 9;
        #1;
        checks++;
        if ({id_ready, rf_we, rf_waddr, rf_wdata, rs2_hazard} !== {1'b0, 1'b1, 5'd9, 32'h55, 1'b1}) begin
            failures++;
            $display("FAIL collide_drain idr=%b we=%b wa=%0d wd=%h hz2=%b required 0/1/9/55/1",
                     id_ready, rf_we, rf_waddr, rf_wdata, rs2_hazard);
        end
        next(); rs2_addr = 9;
        #1;
        checks++;
        if ({id_ready, rf_we, rs2_hazard} !== {1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL collide_after idr=%b we=%b hz2=%b required 1/0/0", id_ready, rf_we, rs2_hazard);
        end
        $display("collision: x4 from LSU, x9 from buffer");
    endtask

    task automatic test_back_to_back();
        next(); load_issue = 1; load_waddr = 10;
        next(); load_issue = 1; load_waddr = 11;
        next(); lsu_rvalid = 1; lsu_rdata = 32'h1; id_we = 1; id_waddr = 9; id_wdata = 32'h99;
        #1;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd10, 32'h1}) begin
            failures++;
            $display("FAIL b2b_resp1 we=%b wa=%0d wd=%h required 1/10/1", rf_we, rf_waddr, rf_wdata);
        end
        next(); lsu_rvalid = 1; lsu_rdata = 32'h2; id_we = 1; id_waddr = 12; id_wdata = 32'h77;
        #1;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata, id_ready, load_ready} !== {1'b1, 5'd11, 32'h2, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL b2b_resp2 we=%b wa=%0d wd=%h idr=%b ldr=%b required 1/11/2/0/0",
                     rf_we, rf_waddr, rf_wdata, id_ready, load_ready);
        end
        next(); id_we = 1; id_waddr = 12; id_wdata = 32'h77;
        #1;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata, id_ready} !== {1'b1, 5'd9, 32'h99, 1'b0}) begin
            failures++;
            $display("FAIL b2b_drain we=%b wa=%0d wd=%h idr=%b required 1/9/99/0", rf_we, rf_waddr, rf_wdata, id_ready);
        end
        next(); id_we = 1; id_waddr = 12; id_wdata = 32'h77;
        #1;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata, id_ready} !== {1'b1, 5'd12, 32'h77, 1'b1}) begin
            failures++;
            $display("FAIL b2b_stalled we=%b wa=%0d wd=%h idr=%b required 1/12/77/1", rf_we, rf_waddr, rf_wdata, id_ready);
        end
        $display("back_to_back: buffer held through two responses");
    endtask

    task automatic test_err();
        next(); load_issue = 1; load_waddr = 6;
        next(); lsu_rvalid = 1; lsu_err = 1; lsu_rdata = 32'hBAD; id_we = 1; id_waddr = 2; id_wdata = 32'h2222;
        #1;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata, id_ready} !== {1'b1, 5'd2, 32'h2222, 1'b1}) begin
            failures++;
            $display("FAIL err_resp we=%b wa=%0d wd=%h idr=%b required 1/2/2222/1", rf_we, rf_waddr, rf_wdata, id_ready);
        end
        next();
        #1;
        checks++;
        if ({loads_pending, rf_we, id_ready} !== {3'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL err_after pend=%0d we=%b idr=%b required 0/0/1", loads_pending, rf_we, id_ready);
        end
        $display("err: x6 dropped, x2 written");
    endtask

    task automatic test_x0_and_reset();
        next(); load_issue = 1; load_waddr = 0;
        next(); lsu_rvalid = 1; lsu_rdata = 32'h1234;
        #1;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 5'd0, 32'd0}) begin
            failures++;
            $display("FAIL x0_resp we=%b wa=%0d wd=%h required 0/0/0", rf_we, rf_waddr, rf_wdata);
        end
        next();
        #1;
        checks++;
        if (loads_pending !== 3'd0) begin
            failures++;
            $display("FAIL x0_pop pend=%0d required 0", loads_pending);
        end
        next(); load_issue = 1; load_waddr = 13;
        next(); load_issue = 1; load_waddr = 14;
        next(); lsu_rvalid = 1; lsu_rdata = 32'h5; id_we = 1; id_waddr = 15; id_wdata = 32'hF;
        next();
        rst_ni = 0;
        #1;
        checks++;
        if ({loads_pending, id_ready, rf_we, load_ready} !== {3'd0, 1'b1, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL mid_reset pend=%0d idr=%b we=%b ldr=%b required 0/1/0/1",
                     loads_pending, id_ready, rf_we, load_ready);
        end
        @(negedge clk);
        rst_ni = 1;
        $display("x0_and_reset: x0 suppressed, state cleared");
    endtask

    task automatic test_random();
        int q[$];
        bit bv;
        int ba;
        logic [31:0] bd;
        int errs = 0;
        do_reset();
        bv = 0; ba = 0; bd = 0;
        for (int n = 0; n < 2000; n++) begin
            bit e_we, e_idr, e_ldr, e_h1, e_h2, lsu_w, id_acc, push, sv;
            int e_wa, sa;
            logic [31:0] e_wd, sd;
            @(negedge clk);
            id_we = 1'($urandom_range(0, 1));
            id_waddr = 5'($urandom_range(0, 7));
            id_wdata = $urandom;
            load_issue = 1'($urandom_range(0, 1));
            load_waddr = 5'($urandom_range(0, 7));
            lsu_rvalid = (q.size() > 0) && ($urandom_range(0, 2) != 0);
            lsu_err = ($urandom_range(0, 4) == 0);
            lsu_rdata = $urandom;
            rs1_addr = 5'($urandom_range(0, 7));
            rs2_addr = 5'($urandom_range(0, 7));
            e_idr = !bv;
            e_ldr = (q.size() < MAX_LOADS) && !bv;
            e_h1 = 0; e_h2 = 0;
            foreach (q[k]) begin
                if (q[k] == int'(rs1_addr)) e_h1 = 1;
                if (q[k] == int'(rs2_addr)) e_h2 = 1;
            end
            if (bv && ba == int'(rs1_addr)) e_h1 = 1;
            if (bv && ba == int'(rs2_addr)) e_h2 = 1;
            if (rs1_addr == 0) e_h1 = 0;
            if (rs2_addr == 0) e_h2 = 0;
            lsu_w = lsu_rvalid && !lsu_err;
            id_acc = id_we && !bv;
            push = load_issue && e_ldr;
            sv = 1; sa = 0; sd = 0;
            if (lsu_w) begin sa = q[0]; sd = lsu_rdata; end
            else if (bv) begin sa = ba; sd = bd; end
            else if (id_acc) begin sa = int'(id_waddr); sd = id_wdata; end
            else sv = 0;
            e_we = sv && sa != 0;
            e_wa = e_we ? sa : 0;
            e_wd = e_we ? sd : 32'd0;
            #1;
            checks++;
            if ({rf_we, rf_waddr, rf_wdata, id_ready, load_ready, rs1_hazard, rs2_hazard, loads_pending}
                !== {e_we, 5'(e_wa), e_wd, e_idr, e_ldr, e_h1, e_h2, 3'(q.size())}) begin
                failures++;
                errs++;
                $display("FAIL random[%0d] we=%b wa=%0d wd=%h idr=%b ldr=%b hz=%b%b pend=%0d required %b/%0d/%h/%b/%b/%b%b/%0d",
                         n, rf_we, rf_waddr, rf_wdata, id_ready, load_ready, rs1_hazard, rs2_hazard, loads_pending,
                         e_we, e_wa, e_wd, e_idr, e_ldr, e_h1, e_h2, q.size());
            end
            if (lsu_rvalid) void'(q.pop_front());
            if (push) q.push_back(int'(load_waddr));
            if (bv) bv = lsu_w;
            else if (id_acc && lsu_w) begin bv = 1; ba = int'(id_waddr); bd = id_wdata; end
        end
        $display("random: 2000 cycles, %0d mismatching", errs);
    endtask

    initial begin
        test_reset();
        test_direct_write();
        test_load_order();
        test_collision();
        test_back_to_back();
        test_err();
        test_x0_and_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
